fft_frame_ctrl: RTL and testbench

Run controller for the 8192-point FFT core (fft_8192_top). It pulses the core reset, enables the core, and counts output beats into frames. It discards a configurable number of leading frames, then streams exactly one frame into a capture RAM write port and signals completion. It also checks frame length against the core's finish flag and watches for a stalled core.

---
 rtl/fft_frame_ctrl_if.sv | 25 ++
 rtl/fft_frame_ctrl.sv | 126 ++++++++++++
 tb/tb_fft_frame_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_ctrl_if.sv
// Bus bundle between the frame controller, the FFT core output stream and the
// capture RAM write port.
interface fft_frame_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
) ();
  logic              core_rst;
  logic              core_en;
  logic              core_dout_valid;
  logic [DATA_W-1:0] core_dout;
  logic              core_dout_finish;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output core_rst, core_en, wr_en, wr_addr, wr_data,
    input  core_dout_valid, core_dout, core_dout_finish
  );

  modport slave (
    input  core_rst, core_en, wr_en, wr_addr, wr_data,
    output core_dout_valid, core_dout, core_dout_finish
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Run controller for the 8192-point FFT core: resets and enables the core,
// discards leading frames, captures one frame, and checks length and stalls.
module fft_frame_ctrl #(
  parameter int N          = 8192,
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 64,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       skip_cfg,
  fft_frame_ctrl_if.master bus,
  output logic             busy,
  output logic             done,
  output logic [7:0]       frame_cnt,
  output logic             err_len,
  output logic             err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(N - 1);

  typedef enum logic [2:0] {IDLE, CORE_RST, SKIP, CAPTURE, DONE} state_t;

  state_t            state, state_nxt;
  logic [7:0]        skip_q;
  logic [RC_W-1:0]   rst_cnt;
  logic [ADDR_W-1:0] beat;
  logic [WD_W-1:0]   wd_cnt;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic running, beat_v, last_beat, wd_fire, skip_end, start_ok;

  assign running   = (state == SKIP) || (state == CAPTURE);
  assign beat_v    = running && bus.core_dout_valid;
  assign last_beat = beat_v && (beat == LAST_BEAT);
  assign wd_fire   = running && !bus.core_dout_valid && (wd_cnt == WD_W'(TIMEOUT - 1));
  // frame_cnt is still below skip_q while skipping, so the 9-bit sum cannot alias.
  assign skip_end  = (state == SKIP) && last_beat &&
                     (({1'b0, frame_cnt} + 9'd1) == {1'b0, skip_q});
  assign start_ok  = (state == IDLE) && start && !abort;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default is assigned before the case so no path leaves state_nxt
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_ok) state_nxt = CORE_RST;
      CORE_RST: if (abort) state_nxt = IDLE;
                else if (rst_cnt == RC_W'(RST_CYCLES - 1))
                  state_nxt = (skip_q != 8'd0) ? SKIP : CAPTURE;
      SKIP:     if (abort || wd_fire) state_nxt = IDLE;
                else if (skip_end)    state_nxt = CAPTURE;
      CAPTURE:  if (abort || wd_fire) state_nxt = IDLE;
                else if (last_beat)   state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_q      <= '0;
      rst_cnt     <= '0;
      beat        <= '0;
      wd_cnt      <= '0;
      frame_cnt   <= '0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (start_ok) begin
        skip_q      <= skip_cfg;
        rst_cnt     <= '0;
        beat        <= '0;
        wd_cnt      <= '0;
        frame_cnt   <= '0;
        err_len     <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (state == CORE_RST) rst_cnt <= rst_cnt + RC_W'(1);
      if (running && !abort) begin
        // Framing follows the beat counter; finish is only cross-checked.
        if (bus.core_dout_finish != last_beat) err_len <= 1'b1;
        if (bus.core_dout_valid) begin
          wd_cnt <= '0;
          beat   <= (beat == LAST_BEAT) ? '0 : beat + ADDR_W'(1);
          if (last_beat && frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
          if (state == CAPTURE) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= beat;
            wr_data_q <= bus.core_dout;
          end
        end else begin
          wd_cnt <= wd_cnt + WD_W'(1);
          if (wd_fire) err_timeout <= 1'b1;
        end
      end
    end
  end

  assign bus.core_rst = (state == IDLE) || (state == CORE_RST);
  assign bus.core_en  = running;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = (state == CORE_RST) || running;
  assign done         = (state == DONE);

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: a frame-level model predicts every
// output each cycle, plus literal checks on counts and key values.
module tb_fft_frame_ctrl;
  localparam int N       = 8192;
  localparam int RSTC    = 4;
  localparam int TIMEOUT = 200;

  localparam int P_IDLE = 0, P_RST = 1, P_RUN = 2, P_DONE = 3;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] skip_cfg;
  logic       busy, done, err_len, err_timeout;
  logic [7:0] frame_cnt;

  fft_frame_ctrl_if #(.ADDR_W(13), .DATA_W(64)) bus ();

  fft_frame_ctrl #(.N(N), .ADDR_W(13), .DATA_W(64), .RST_CYCLES(RSTC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .skip_cfg(skip_cfg),
    .bus(bus), .busy(busy), .done(done), .frame_cnt(frame_cnt),
    .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: global beat count since start decides frame and capture.
  int          m_phase = P_IDLE;
  int          m_rst_left, m_gbeats, m_skip, m_idle;
  logic        e_wr_en = 0, e_err_len = 0, e_err_to = 0, e_after_rst = 1;
  logic [12:0] e_wr_addr = 0;
  logic [63:0] e_wr_data = 0;
  int          e_frame = 0;
  bit          chk_on = 0;

  int          wr_count, done_count;
  logic [63:0] first_wr_data;

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", busy, (m_phase == P_RUN || m_phase == P_RST));
      check("core_en", bus.core_en, (m_phase == P_RUN));
      if (m_phase != P_DONE) check("core_rst", bus.core_rst, (m_phase != P_RUN));
      check("done", done, (m_phase == P_DONE));
      check("wr_en", bus.wr_en, e_wr_en);
      if (e_wr_en || e_after_rst) begin
        check("wr_addr", bus.wr_addr, e_wr_addr);
        check("wr_data", bus.wr_data, e_wr_data);
      end
      check("frame_cnt", frame_cnt, e_frame);
      check("err_len", err_len, e_err_len);
      check("err_timeout", err_timeout, e_err_to);
      if (bus.wr_en === 1'b1) begin
        if (wr_count == 0) first_wr_data = bus.wr_data;
        wr_count++;
      end
      if (done === 1'b1) done_count++;
    end
    e_wr_en     = 0;
    e_after_rst = 0;
    if (rst) begin
      m_phase = P_IDLE; e_frame = 0; e_err_len = 0; e_err_to = 0;
      e_wr_addr = 0; e_wr_data = 0; e_after_rst = 1;
    end else begin
      case (m_phase)
        P_IDLE: if (start && !abort) begin
          m_phase = P_RST; m_rst_left = RSTC; m_gbeats = 0; m_idle = 0;
          m_skip = skip_cfg; e_frame = 0; e_err_len = 0; e_err_to = 0;
        end
        P_RST: begin
          if (abort) m_phase = P_IDLE;
          else begin
            m_rst_left--;
            if (m_rst_left == 0) m_phase = P_RUN;
          end
        end
        P_RUN: begin
          if (abort) m_phase = P_IDLE;
          else if (bus.core_dout_valid) begin
            int pos, fr;
            pos = m_gbeats % N;
            fr  = m_gbeats / N;
            m_idle = 0;
            if ((pos == N - 1) != bus.core_dout_finish) e_err_len = 1;
            if (fr >= m_skip) begin
              e_wr_en = 1; e_wr_addr = 13'(pos); e_wr_data = bus.core_dout;
            end
            m_gbeats++;
            if (pos == N - 1) begin
              if (e_frame < 255) e_frame++;
              if (fr == m_skip) m_phase = P_DONE;
            end
          end else begin
            if (bus.core_dout_finish) e_err_len = 1;
            m_idle++;
            if (m_idle == TIMEOUT) begin
              e_err_to = 1; m_phase = P_IDLE;
            end
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tally();
    wr_count = 0; done_count = 0; first_wr_data = '1;
  endtask

  task automatic do_start(input logic [7:0] skip);
    start = 1; skip_cfg = skip;
    tick();
    start = 0;
  endtask

  task automatic wait_en(output int k);
    k = 0;
    while (bus.core_en !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check("core_en_rise", bus.core_en, 1'b1);
  endtask

  task automatic send_beats(input int first, input int count, input int gap,
                            input int fin_beat, input bit fin_last);
    for (int g = first; g < first + count; g++) begin
      bus.core_dout_valid  = 1;
      bus.core_dout        = 64'(g);
      bus.core_dout_finish = (g == fin_beat) || (fin_last && (g % N == N - 1));
      tick();
      bus.core_dout_valid  = 0;
      bus.core_dout_finish = 0;
      repeat (gap) tick();
    end
  endtask

  initial begin
    int k;
    rst = 1; start = 0; abort = 0; skip_cfg = 0;
    bus.core_dout_valid = 0; bus.core_dout = '0; bus.core_dout_finish = 0;
    clear_tally();
    tick(); tick();
    chk_on = 1;
    check("rst_core_rst", bus.core_rst, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst = 0;
    tick();
    check("post_rst_core_rst", bus.core_rst, 1'b1);
    check("post_rst_core_en", bus.core_en, 1'b0);

    // 1: single frame capture, start ignored in DONE, start accepted on first IDLE
    clear_tally();
    do_start(8'd0);
    check("t1_busy", busy, 1'b1);
    wait_en(k);
    check("t1_rst_cycles", k, 4);
    send_beats(0, N, 0, -1, 1);
    check("t1_done", done, 1'b1);
    check("t1_last_addr", bus.wr_addr, 13'd8191);
    check("t1_last_data", bus.wr_data, 64'd8191);
    check("t1_frame_cnt", frame_cnt, 8'd1);
    start = 1; tick(); start = 0;
    check("t1_start_in_done_ignored", busy, 1'b0);
    check("t1_writes", wr_count, N);
    check("t1_dones", done_count, 1);
    start = 1; tick(); start = 0;
    check("t1_start_first_idle", busy, 1'b1);
    abort = 1; start = 1; tick(); abort = 0; start = 0;
    check("t1_abort_in_rst", busy, 1'b0);
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    check("t1_abort_beats_start", busy, 1'b0);

    // 2: skip two frames, capture the third
    clear_tally();
    do_start(8'd2);
    wait_en(k);
    send_beats(0, 3 * N, 0, -1, 1);
    check("t2_done", done, 1'b1);
    check("t2_frame_cnt", frame_cnt, 8'd3);
    tick();
    check("t2_writes", wr_count, N);
    check("t2_first_data", first_wr_data, 64'd16384);
    check("t2_dones", done_count, 1);

    // 3: valid every third cycle
    clear_tally();
    do_start(8'd0);
    wait_en(k);
    send_beats(0, N, 2, -1, 1);
    tick();
    check("t3_writes", wr_count, N);
    check("t3_dones", done_count, 1);

    // 4: finish misplaced on beat 100 and missing on beat 8191
    clear_tally();
    do_start(8'd0);
    wait_en(k);
    send_beats(0, 101, 0, 100, 0);
    check("t4_err_len_early", err_len, 1'b1);
    send_beats(101, N - 101, 0, -1, 0);
    check("t4_done", done, 1'b1);
    tick();
    check("t4_err_len_kept", err_len, 1'b1);
    check("t4_dones", done_count, 1);

    // 5: stall after beat 500 trips the watchdog after exactly TIMEOUT idle cycles
    clear_tally();
    do_start(8'd0);
    wait_en(k);
    send_beats(0, 501, 0, -1, 1);
    k = 0;
    while (err_timeout !== 1'b1 && k < 1000) begin
      tick();
      k++;
    end
    check("t5_idle_cycles", k, TIMEOUT);
    check("t5_busy", busy, 1'b0);
    check("t5_core_en", bus.core_en, 1'b0);
    check("t5_dones", done_count, 0);
    do_start(8'd0);
    check("t5_err_cleared", err_timeout, 1'b0);

    // 6: abort at beat 4000 of capture, then rst in the middle of a second run
    clear_tally();
    wait_en(k);
    send_beats(0, 4000, 0, -1, 1);
    bus.core_dout_valid = 1; bus.core_dout = 64'd4000; abort = 1;
    tick();
    bus.core_dout_valid = 0; abort = 0;
    check("t6_abort_busy", busy, 1'b0);
    check("t6_abort_core_en", bus.core_en, 1'b0);
    check("t6_abort_wr_en", bus.wr_en, 1'b0);
    do_start(8'd0);
    wait_en(k);
    send_beats(0, 100, 0, -1, 1);
    rst = 1; bus.core_dout_valid = 1;
    tick();
    rst = 0; bus.core_dout_valid = 0;
    check("t6_rst_core_rst", bus.core_rst, 1'b1);
    check("t6_rst_frame_cnt", frame_cnt, 8'd0);
    check("t6_rst_wr_addr", bus.wr_addr, 13'd0);
    repeat (10) tick();
    check("t6_dones", done_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
